// File: rtl/mul_controller.sv
// mul_controller: sequencing FSM for a repeated-addition multiplier.
// Handshakes A then B in, then adds A into P once per count of B.
module mul_controller #(
    parameter int          CNT_W    = 16,
    parameter int unsigned MAX_ITER = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             eqz,
    output logic             ldA,
    output logic             ldB,
    output logic             clrP,
    output logic             ldP,
    output logic             decB,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] iter_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_ADD,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            iter_count  <= '0;
            err_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                iter_count  <= '0;
                err_timeout <= 1'b0;
            end else begin
                if (cnt_inc) iter_count <= iter_count + 1'b1;
                if (err_set) err_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        clrP     = 1'b0;
        ldP      = 1'b0;
        decB     = 1'b0;
        done     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        err_set  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    cnt_clr = 1'b1;
                end
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                ldA      = in_valid;
                if (in_valid) state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                ldB      = in_valid;
                clrP     = in_valid;
                if (in_valid) state_d = S_ADD;
            end
            S_ADD: begin
                // eqz reflects B as registered at the previous edge
                if (eqz) begin
                    state_d = S_DONE;
                end else if (iter_count < MAX_CNT) begin
                    ldP     = 1'b1;
                    decB    = 1'b1;
                    cnt_inc = 1'b1;
                end else begin
                    err_set = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // abort wins over every strobe and transition outside IDLE
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            in_ready = 1'b0;
            ldA      = 1'b0;
            ldB      = 1'b0;
            clrP     = 1'b0;
            ldP      = 1'b0;
            decB     = 1'b0;
            done     = 1'b0;
            cnt_inc  = 1'b0;
            err_set  = 1'b0;
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule
